// File: rtl/request_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | request_queue_if : request types plus the parser-side and scheduler-side |
// |                    handshake bundle of the request queue                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

typedef enum logic [1:0] {
  READ   = 2'd0,
  WRITE  = 2'd1,
  IFETCH = 2'd2,
  NOP    = 2'd3
} parsed_op_t;

localparam int ADDRESS_WIDTH = 40;

interface request_queue_if #(
  parameter int AW = ADDRESS_WIDTH,
  parameter int TW = 32
);
  logic          in_valid;
  parsed_op_t    in_opcode;
  logic [AW-1:0] in_address;
  logic [TW-1:0] in_time;
  logic          in_ready;

  logic          out_valid;
  parsed_op_t    out_opcode;
  logic [AW-1:0] out_address;
  logic [TW-1:0] out_time;
  logic          out_ready;

  // master is the parser/scheduler side; slave is the queue itself
  modport master (
    output in_valid, in_opcode, in_address, in_time, out_ready,
    input  in_ready, out_valid, out_opcode, out_address, out_time
  );

  modport slave (
    input  in_valid, in_opcode, in_address, in_time, out_ready,
    output in_ready, out_valid, out_opcode, out_address, out_time
  );
endinterface

`default_nettype wire

// File: rtl/request_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | request_queue : in-order FIFO of parsed memory requests feeding the DRAM |
// |                 scheduler; optional same-cycle bypass when               |
// |                 REQUEST_QUEUE_BYPASS_EN is defined                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module request_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = ADDRESS_WIDTH,
  parameter int TW    = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  request_queue_if.slave              bus,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  parsed_op_t          r_mem_op   [DEPTH];
  logic [AW-1:0]       r_mem_addr [DEPTH];
  logic [TW-1:0]       r_mem_time [DEPTH];

  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_overflow;

  logic                w_full;
  logic                w_empty;
  logic                w_in_req;
  logic                w_bypass;
  logic                w_enq;
  logic                w_deq;

  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_in_req = bus.in_valid && (bus.in_opcode != NOP);

`ifdef REQUEST_QUEUE_BYPASS_EN
  // An empty queue with a ready consumer hands the request straight through.
  assign w_bypass = w_empty && w_in_req && bus.out_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq = w_in_req && !w_full && !w_bypass;
  assign w_deq = !w_empty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_op[r_wptr]   <= bus.in_opcode;
      r_mem_addr[r_wptr] <= bus.in_address;
      r_mem_time[r_wptr] <= bus.in_time;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - 1'b1;
      end
      // A request arriving while full is lost even if a dequeue frees a slot.
      if (w_in_req && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.out_valid   = 1'b0;
    bus.out_opcode  = NOP;
    bus.out_address = '0;
    bus.out_time    = '0;
    if (w_bypass) begin
      bus.out_valid   = 1'b1;
      bus.out_opcode  = bus.in_opcode;
      bus.out_address = bus.in_address;
      bus.out_time    = bus.in_time;
    end else if (!w_empty) begin
      bus.out_valid   = 1'b1;
      bus.out_opcode  = r_mem_op[r_rptr];
      bus.out_address = r_mem_addr[r_rptr];
      bus.out_time    = r_mem_time[r_rptr];
    end
  end

  assign bus.in_ready = !w_full;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_request_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_request_queue : directed self-checking bench for request_queue        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module tb_request_queue;

  logic       clk;
  logic       rst;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  request_queue_if #(.AW(ADDRESS_WIDTH), .TW(32)) bus ();

  request_queue #(.DEPTH(16), .AW(ADDRESS_WIDTH), .TW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input parsed_op_t op, input logic [39:0] a, input logic [31:0] t);
    bus.in_valid   = v;
    bus.in_opcode  = op;
    bus.in_address = a;
    bus.in_time    = t;
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, NOP, 40'h0, 32'h0);

    // reset then idle
    step();
    step();
    rst = 1'b0;
    step();
    check_val("rst_count",    64'(count),         64'd0);
    check_val("rst_empty",    64'(empty),         64'd1);
    check_val("rst_full",     64'(full),          64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready),  64'd1);
    check_val("rst_out_valid",64'(bus.out_valid), 64'd0);
    check_val("rst_overflow", 64'(overflow),      64'd0);
    check_val("rst_out_op",   64'(bus.out_opcode),64'(NOP));

    // single request, visible one cycle later
    drive(1'b1, READ, 40'h1_0000_0040, 32'd5);
    #1;
    check_val("single_latency", 64'(bus.out_valid), 64'd0);
    step();
    drive(1'b0, NOP, 40'h0, 32'h0);
    check_val("single_valid", 64'(bus.out_valid),   64'd1);
    check_val("single_op",    64'(bus.out_opcode),  64'(READ));
    check_val("single_addr",  64'(bus.out_address), 64'h1_0000_0040);
    check_val("single_time",  64'(bus.out_time),    64'd5);
    check_val("single_count", 64'(count),           64'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_val("single_empty", 64'(empty),           64'd1);
    check_val("single_addr0", 64'(bus.out_address), 64'd0);

    // fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, WRITE, 40'(i), 32'(100 + i));
      step();
    end
    drive(1'b1, WRITE, 40'd16, 32'd116);
    check_val("fill_full",     64'(full),         64'd1);
    check_val("fill_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("fill_count",    64'(count),        64'd16);
    check_val("fill_no_ovf",   64'(overflow),     64'd0);
    step();
    check_val("ovf_set",   64'(overflow), 64'd1);
    check_val("ovf_count", 64'(count),    64'd16);

    // dequeue while full: the offered request is still refused
    drive(1'b1, WRITE, 40'd99, 32'd99);
    bus.out_ready = 1'b1;
    check_val("drain_addr0", 64'(bus.out_address), 64'd0);
    step();
    drive(1'b0, NOP, 40'h0, 32'h0);
    check_val("full_deq_count", 64'(count), 64'd15);
    for (int i = 1; i < 16; i++) begin
      check_val("drain_addr", 64'(bus.out_address), 64'(i));
      check_val("drain_time", 64'(bus.out_time),    64'(100 + i));
      step();
    end
    check_val("drain_empty",  64'(empty),    64'd1);
    check_val("drain_count",  64'(count),    64'd0);
    check_val("ovf_sticky",   64'(overflow), 64'd1);
    // out_ready held high on an empty queue must not underflow
    step();
    check_val("empty_no_underflow", 64'(count), 64'd0);

    // simultaneous enqueue/dequeue at count 8 across the pointer wrap
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, READ, 40'(32'h1000 + k), 32'(k));
      step();
    end
    check_val("steady_pre_count", 64'(count), 64'd8);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, READ, 40'(32'h1000 + 8 + j), 32'(8 + j));
      check_val("steady_addr", 64'(bus.out_address), 64'(32'h1000 + j));
      step();
      check_val("steady_count", 64'(count), 64'd8);
    end
    drive(1'b0, NOP, 40'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      check_val("steady_tail", 64'(bus.out_address), 64'(32'h1000 + 20 + k));
      step();
    end
    check_val("steady_empty", 64'(empty), 64'd1);
    bus.out_ready = 1'b0;

    // reset clears the sticky overflow
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst2_overflow", 64'(overflow), 64'd0);

    // NOP filtering
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, NOP, 40'(k), 32'(k));
      step();
    end
    check_val("nop_count",    64'(count),         64'd0);
    check_val("nop_overflow", 64'(overflow),      64'd0);
    check_val("nop_valid",    64'(bus.out_valid), 64'd0);

    // reset mid-operation at count 5
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, READ, 40'(32'h500 + k), 32'(k));
      step();
    end
    drive(1'b0, NOP, 40'h0, 32'h0);
    check_val("pre_rst_count", 64'(count), 64'd5);
    rst = 1'b1;
    step();
    check_val("mid_rst_count", 64'(count),         64'd0);
    check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    step();

    // IFETCH offered to an empty queue with a ready consumer
    drive(1'b1, IFETCH, 40'h200, 32'd9);
    bus.out_ready = 1'b1;
    #1;
`ifdef REQUEST_QUEUE_BYPASS_EN
    check_val("byp_valid", 64'(bus.out_valid),   64'd1);
    check_val("byp_addr",  64'(bus.out_address), 64'h200);
    check_val("byp_op",    64'(bus.out_opcode),  64'(IFETCH));
    check_val("byp_time",  64'(bus.out_time),    64'd9);
    step();
    drive(1'b0, NOP, 40'h0, 32'h0);
    check_val("byp_count", 64'(count), 64'd0);
    check_val("byp_empty", 64'(empty), 64'd1);
`else
    check_val("nobyp_valid", 64'(bus.out_valid), 64'd0);
    step();
    drive(1'b0, NOP, 40'h0, 32'h0);
    check_val("nobyp_valid1", 64'(bus.out_valid),   64'd1);
    check_val("nobyp_addr",   64'(bus.out_address), 64'h200);
    check_val("nobyp_count",  64'(count),           64'd1);
    step();
    check_val("nobyp_drain",  64'(count),           64'd0);
`endif
    bus.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
